// File: rtl/qam_tx_sched_if.sv
// qam_tx_sched_if -- payload byte stream into the QAM TX frame scheduler.
// Signals:
//   s_data   8  payload byte
//   s_valid  1  s_data is valid
//   s_last   1  s_data is the final byte of the frame
//   s_ready  1  byte accepted on a cycle with s_valid && s_ready
// Modports: master = byte source, slave = scheduler.
interface qam_tx_sched_if;
    logic [7:0] s_data;
    logic       s_valid;
    logic       s_last;
    logic       s_ready;

    modport master (output s_data, output s_valid, output s_last, input s_ready);
    modport slave  (input s_data, input s_valid, input s_last, output s_ready);
endinterface

// File: rtl/qam_tx_sched.sv
// qam_tx_sched -- frame scheduler in front of the 2-QAM (BPSK) symbol mapper.
// Accepts payload bytes on a valid/ready stream and paces one bit per symbol
// slot: preamble, payload MSB-first, optional CRC-8, then a silent guard gap.
// Build option: define QAM_TX_SCHED_CRC8_EN to append a CRC-8 over the payload
// (poly 0x07, init 0x00, no final XOR); undefined, PAY goes straight to GAP.
// Ports:
//   clk         system clock, posedge
//   rst         asynchronous active-low reset
//   s (slave)   s_data / s_valid / s_last in, s_ready out
//   bit_out     symbol bit to the mapper, held between strobes, 0 in GAP
//   bit_valid   1-clk strobe: bit_out is a new symbol
//   busy        high in every state other than IDLE
//   underrun    1-clk pulse: a payload slot found no byte available
//   frame_done  1-clk pulse on the GAP -> IDLE transition
module qam_tx_sched #(
    parameter int unsigned SYM_DIV  = 4,
    parameter int unsigned PRE_BITS = 16,
    parameter logic [31:0] PRE_WORD = 32'hAAAA,
    parameter int unsigned GAP_SYMS = 8
) (
    input  logic          clk,
    input  logic          rst,
    qam_tx_sched_if.slave s,
    output logic          bit_out,
    output logic          bit_valid,
    output logic          busy,
    output logic          underrun,
    output logic          frame_done
);
    localparam int unsigned SW   = (SYM_DIV > 1) ? $clog2(SYM_DIV) : 1;
    // One phase counter serves preamble, payload bit index, CRC and gap.
    localparam int unsigned CMAX = (GAP_SYMS > 32) ? GAP_SYMS : 32;
    localparam int unsigned CW   = $clog2(CMAX);

`ifdef QAM_TX_SCHED_CRC8_EN
    typedef enum logic [2:0] {ST_IDLE, ST_PRE, ST_PAY, ST_CRC, ST_GAP} state_t;
`else
    typedef enum logic [1:0] {ST_IDLE, ST_PRE, ST_PAY, ST_GAP} state_t;
`endif

    state_t        state;
    logic [SW-1:0] sym_cnt;
    logic [CW-1:0] cnt;
    logic [7:0]    hold_data;
    logic          hold_full;
    logic          hold_last;
    logic          last_acc;   // final byte of the frame already accepted
    logic [7:0]    shift;
    logic          cur_last;   // byte now being shifted out is the final one
    logic          run;        // low only until the first clock after reset
`ifdef QAM_TX_SCHED_CRC8_EN
    logic [7:0]    crc;
    logic [7:0]    crc_next;
`endif

    logic       slot;
    logic       accept;
    logic       need_byte;
    logic [7:0] cur_byte;
    logic [4:0] pre_idx;

    assign slot      = (state != ST_IDLE) && (sym_cnt == SW'(SYM_DIV - 1));
    assign accept    = s.s_valid && s.s_ready;
    // Bit index 0 of a payload byte takes its bit straight from hold, so the
    // shift register reload and the first bit of the new byte share one slot.
    assign need_byte = (cnt[2:0] == 3'd0);
    assign cur_byte  = need_byte ? hold_data : shift;
    assign pre_idx   = 5'(PRE_BITS - 1) - cnt[4:0];
    assign busy      = (state != ST_IDLE);

    // NOTE: s_ready is gated by the registered run flag so it stays 0 while
    // rst is low, even though IDLE with an empty hold would otherwise decode
    // as ready.
    assign s.s_ready = run && !hold_full && !last_acc &&
                       (state == ST_IDLE || state == ST_PRE || state == ST_PAY);

`ifdef QAM_TX_SCHED_CRC8_EN
    assign crc_next = {crc[6:0], 1'b0} ^ ((crc[7] ^ cur_byte[7]) ? 8'h07 : 8'h00);
`endif

    // NOTE: every register here is assigned with <= so all updates see the
    // pre-edge values; mixing in blocking assignments would make results
    // depend on statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            sym_cnt    <= '0;
            cnt        <= '0;
            hold_data  <= '0;
            hold_full  <= 1'b0;
            hold_last  <= 1'b0;
            last_acc   <= 1'b0;
            shift      <= '0;
            cur_last   <= 1'b0;
            run        <= 1'b0;
            bit_out    <= 1'b0;
            bit_valid  <= 1'b0;
            underrun   <= 1'b0;
            frame_done <= 1'b0;
`ifdef QAM_TX_SCHED_CRC8_EN
            crc        <= '0;
`endif
        end else begin
            run        <= 1'b1;
            bit_valid  <= 1'b0;
            underrun   <= 1'b0;
            frame_done <= 1'b0;

            if (state == ST_IDLE) sym_cnt <= '0;
            else if (slot)        sym_cnt <= '0;
            else                  sym_cnt <= sym_cnt + SW'(1);

            // A load needs an empty hold and a consume needs a full one, so
            // the two never collide on the same edge.
            if (accept) begin
                hold_data <= s.s_data;
                hold_last <= s.s_last;
                hold_full <= 1'b1;
                if (s.s_last) last_acc <= 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    cnt      <= '0;
                    cur_last <= 1'b0;
`ifdef QAM_TX_SCHED_CRC8_EN
                    crc      <= '0;
`endif
                    if (accept) state <= ST_PRE;
                end

                ST_PRE: if (slot) begin
                    bit_out   <= PRE_WORD[pre_idx];
                    bit_valid <= 1'b1;
                    if (cnt == CW'(PRE_BITS - 1)) begin
                        cnt   <= '0;
                        state <= ST_PAY;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end

                ST_PAY: if (slot) begin
                    if (need_byte && !hold_full) begin
                        // Stall: no strobe, index holds, resume on arrival.
                        underrun <= 1'b1;
                    end else begin
                        bit_out   <= cur_byte[7];
                        bit_valid <= 1'b1;
                        shift     <= {cur_byte[6:0], 1'b0};
`ifdef QAM_TX_SCHED_CRC8_EN
                        crc       <= crc_next;
`endif
                        if (need_byte) begin
                            hold_full <= 1'b0;
                            cur_last  <= hold_last;
                        end
                        if (cnt[2:0] == 3'd7) begin
                            cnt <= '0;
                            if (cur_last) begin
`ifdef QAM_TX_SCHED_CRC8_EN
                                state <= ST_CRC;
`else
                                state <= ST_GAP;
`endif
                            end
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                end

`ifdef QAM_TX_SCHED_CRC8_EN
                ST_CRC: if (slot) begin
                    bit_out   <= crc[7];
                    bit_valid <= 1'b1;
                    crc       <= {crc[6:0], 1'b0};
                    if (cnt == CW'(7)) begin
                        cnt   <= '0;
                        state <= ST_GAP;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
`endif

                ST_GAP: begin
                    bit_out <= 1'b0;
                    if (slot) begin
                        if (cnt == CW'(GAP_SYMS - 1)) begin
                            cnt        <= '0;
                            last_acc   <= 1'b0;
                            frame_done <= 1'b1;
                            state      <= ST_IDLE;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_qam_tx_sched.sv
// tb_qam_tx_sched -- self-checking bench for qam_tx_sched.
// Expected symbol bits are pushed to a scoreboard queue when each byte is
// handed over and popped on every bit_valid strobe. Timing (latency, slot
// spacing, gap length, underrun count) is derived from the handshake cycle.
// Define QAM_TX_SCHED_CRC8_EN for both files to exercise the CRC build.
`timescale 1ns/1ps
module tb_qam_tx_sched;
    localparam int          SYM_DIV  = 4;
    localparam int          PRE_BITS = 16;
    localparam logic [31:0] PRE_WORD = 32'hAAAA;
    localparam int          GAP_SYMS = 8;
`ifdef QAM_TX_SCHED_CRC8_EN
    localparam int          CRC_BITS = 8;
`else
    localparam int          CRC_BITS = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic bit_out, bit_valid, busy, underrun, frame_done;

    qam_tx_sched_if sif ();

    qam_tx_sched #(
        .SYM_DIV (SYM_DIV),
        .PRE_BITS(PRE_BITS),
        .PRE_WORD(PRE_WORD),
        .GAP_SYMS(GAP_SYMS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .s         (sif.slave),
        .bit_out   (bit_out),
        .bit_valid (bit_valid),
        .busy      (busy),
        .underrun  (underrun),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    bit   exp_q[$];
    int   strobe_cyc[$];
    int   n_under = 0;
    int   n_fd    = 0;
    int   n_busy_low = 0;
    int   fd_cyc  = 0;
    int   hs_cyc  = 0;
    logic [7:0] crc_m;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    function automatic logic [7:0] crc8_byte(input logic [7:0] c, input logic [7:0] d);
        logic [7:0] r;
        r = c;
        for (int i = 7; i >= 0; i--)
            r = (r[7] ^ d[i]) ? ({r[6:0], 1'b0} ^ 8'h07) : {r[6:0], 1'b0};
        return r;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (bit_valid) begin
            if (exp_q.size() == 0) begin
                check("extra_strobe", 32'(exp_q.size()), 32'd1);
            end else begin
                bit e;
                e = exp_q.pop_front();
                check("bit", 32'(bit_out), 32'(e));
            end
            strobe_cyc.push_back(cyc);
        end
        if (underrun)   n_under++;
        if (!busy)      n_busy_low++;
        if (frame_done) begin
            n_fd++;
            fd_cyc = cyc;
        end
    end

    // Present one byte; on the handshake push its expected bits (preamble
    // first for the opening byte, CRC after the closing one).
    task automatic send_byte(input logic [7:0] d, input bit last, input bit first, input bit keep_valid);
        int t;
        @(negedge clk);
        sif.s_data  = d;
        sif.s_valid = 1'b1;
        sif.s_last  = last;
        t = 0;
        while (!sif.s_ready && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (!sif.s_ready) begin
            check("hs_timeout", 32'(sif.s_ready), 32'd1);
            sif.s_valid = 1'b0;
            return;
        end
        hs_cyc = cyc;
        if (first) begin
            crc_m = 8'h00;
            for (int i = PRE_BITS - 1; i >= 0; i--) exp_q.push_back(PRE_WORD[i]);
        end
        for (int i = 7; i >= 0; i--) exp_q.push_back(d[i]);
        crc_m = crc8_byte(crc_m, d);
        if (last && CRC_BITS != 0)
            for (int i = 7; i >= 0; i--) exp_q.push_back(crc_m[i]);
        @(posedge clk);
        #1;
        if (!keep_valid) sif.s_valid = 1'b0;
    endtask

    task automatic wait_frame_done(input int budget);
        int start;
        int t;
        start = n_fd;
        t = 0;
        while (n_fd == start && t < budget) begin
            @(negedge clk);
            #1;
            t++;
        end
        if (n_fd == start) check("fd_timeout", 32'(n_fd), 32'(start + 1));
    endtask

    task automatic wait_strobes(input int target, input int budget);
        int t;
        t = 0;
        while (strobe_cyc.size() < target && t < budget) begin
            @(negedge clk);
            #1;
            t++;
        end
        if (strobe_cyc.size() < target) check("strobe_timeout", 32'(strobe_cyc.size()), 32'(target));
    endtask

    // Count strobe pairs in [first, first+n) whose spacing is not one slot.
    function automatic int spacing_errors(input int first, input int n);
        int bad;
        bad = 0;
        for (int i = first + 1; i < first + n && i < strobe_cyc.size(); i++)
            if (strobe_cyc[i] - strobe_cyc[i-1] != SYM_DIV) bad++;
        return bad;
    endfunction

    initial begin
        int s0, n, u0, b0, h, last_c, fd_a, na, exp_u;

        #600_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0, n, u0, b0, h, last_c, fd_a, na, exp_u;

        // Reset: held low with s_valid asserted, outputs must stay 0.
        sif.s_data  = 8'h55;
        sif.s_valid = 1'b1;
        sif.s_last  = 1'b0;
        rst         = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("rst_outputs", 32'({sif.s_ready, bit_out, bit_valid, busy, underrun, frame_done}), 32'd0);
        end
        rst         = 1'b1;
        sif.s_valid = 1'b0;
        @(negedge clk);
        check("ready_after_release", 32'(sif.s_ready), 32'd1);
        repeat (20) @(negedge clk);
        check("no_strobe_before_hs", 32'(strobe_cyc.size()), 32'd0);
        check("idle_not_busy", 32'(busy), 32'd0);

        // Single-byte frame 0xC3.
        s0 = strobe_cyc.size();
        u0 = n_under;
        send_byte(8'hC3, 1'b1, 1'b1, 1'b0);
        h  = hs_cyc;
        b0 = n_busy_low;
        wait_frame_done(400);
        n = strobe_cyc.size() - s0;
        check("c3_strobes", 32'(n), 32'(PRE_BITS + 8 + CRC_BITS));
        if (n > 0) begin
            check("c3_first_latency", 32'(strobe_cyc[s0] - h), 32'(SYM_DIV + 1));
            check("c3_spacing", 32'(spacing_errors(s0, n)), 32'd0);
            check("c3_gap", 32'(fd_cyc - strobe_cyc[s0+n-1]), 32'(GAP_SYMS * SYM_DIV));
        end
        // Busy may only be low on the frame_done cycle (already IDLE).
        check("c3_busy_high", 32'(n_busy_low - b0), 32'd1);
        check("c3_bitout_gap", 32'(bit_out), 32'd0);
        check("c3_no_underrun", 32'(n_under - u0), 32'd0);
        check("c3_sb_empty", 32'(exp_q.size()), 32'd0);
        repeat (3) @(negedge clk);

        // Underrun: second byte arrives well after the first drained.
        s0 = strobe_cyc.size();
        u0 = n_under;
        send_byte(8'hFF, 1'b0, 1'b1, 1'b0);
        wait_strobes(s0 + PRE_BITS + 8, 500);
        last_c = strobe_cyc[strobe_cyc.size()-1];
        repeat (40) @(negedge clk);
        send_byte(8'h00, 1'b1, 1'b0, 1'b0);
        wait_frame_done(1000);
        n = strobe_cyc.size() - s0;
        // Slots fire every SYM_DIV clks after last_c; each slot up to and
        // including the handshake edge (hs_cyc + 1) finds hold empty.
        exp_u = (hs_cyc + 1 - last_c) / SYM_DIV;
        check("ur_strobes", 32'(n), 32'(PRE_BITS + 16 + CRC_BITS));
        check("ur_pulses", 32'(n_under - u0), 32'(exp_u));
        if (n > PRE_BITS + 8) begin
            check("ur_resume", 32'(strobe_cyc[s0+PRE_BITS+8] - last_c), 32'(SYM_DIV * (exp_u + 1)));
            check("ur_gap", 32'(fd_cyc - strobe_cyc[s0+n-1]), 32'(GAP_SYMS * SYM_DIV));
        end
        check("ur_sb_empty", 32'(exp_q.size()), 32'd0);
        repeat (3) @(negedge clk);

        // Reset mid-frame during the 5th payload bit.
        s0 = strobe_cyc.size();
        send_byte(8'h5A, 1'b0, 1'b1, 1'b0);
        send_byte(8'h3C, 1'b1, 1'b0, 1'b0);
        wait_strobes(s0 + PRE_BITS + 5, 500);
        #2;
        rst = 1'b0;
        #1;
        check("midrst_async", 32'({sif.s_ready, bit_out, bit_valid, busy, underrun, frame_done}), 32'd0);
        exp_q.delete();
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        s0 = strobe_cyc.size();
        send_byte(8'h81, 1'b1, 1'b1, 1'b0);
        h = hs_cyc;
        wait_frame_done(400);
        n = strobe_cyc.size() - s0;
        check("postrst_strobes", 32'(n), 32'(PRE_BITS + 8 + CRC_BITS));
        if (n > 0) check("postrst_latency", 32'(strobe_cyc[s0] - h), 32'(SYM_DIV + 1));
        check("postrst_sb_empty", 32'(exp_q.size()), 32'd0);
        repeat (3) @(negedge clk);

        // Back-to-back 2-byte frames with s_valid held high.
        s0 = strobe_cyc.size();
        na = PRE_BITS + 16 + CRC_BITS;
        send_byte(8'h12, 1'b0, 1'b1, 1'b1);
        send_byte(8'hE7, 1'b1, 1'b0, 1'b1);
        send_byte(8'h96, 1'b0, 1'b1, 1'b1);
        fd_a = fd_cyc;
        h    = hs_cyc;
        send_byte(8'h0F, 1'b1, 1'b0, 1'b0);
        wait_frame_done(1000);
        n = strobe_cyc.size() - s0;
        // First ready after the closing handshake is the IDLE cycle itself.
        check("b2b_ready_at_idle", 32'(h), 32'(fd_a));
        check("b2b_strobes", 32'(n), 32'(2 * na));
        if (n > na) begin
            check("b2b_frame_sep", 32'(strobe_cyc[s0+na] - strobe_cyc[s0+na-1]),
                  32'(GAP_SYMS * SYM_DIV + 1 + SYM_DIV));
            check("b2b_spacing_a", 32'(spacing_errors(s0, na)), 32'd0);
            check("b2b_spacing_b", 32'(spacing_errors(s0 + na, n - na)), 32'd0);
        end
        check("b2b_sb_empty", 32'(exp_q.size()), 32'd0);

        repeat (5) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
